// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end. It generates the PC, issues reads to a 1-cycle-latency IMEM,
// and feeds decode from a small in-order prefetch queue over a valid/ready handshake.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  output logic                     imem_en,
  output logic [IMEM_AW-1:0]       imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     if_id_valid,
  output logic [31:0]              if_id_ir,
  output logic [31:0]              if_id_npc,
  input  logic                     id_ready,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   irMem_q  [DEPTH];
  logic [31:0]   npcMem_q [DEPTH];

  logic          idValid, push, pop, issue;
  logic [31:0]   redirPc, fetchPc;
  logic [CW-1:0] occAfter;

  // A new read may only issue if its response is guaranteed a slot after this cycle's push/pop
  always_comb begin
    redirPc    = redirect_pc & 32'hFFFF_FFFC;
    idValid    = (count_q != '0) && !redirect_valid;
    pop        = idValid && id_ready;
    push       = inflight_q && !redirect_valid;
    occAfter   = count_q + CW'(push) - CW'(pop);
    fetchPc    = redirect_valid ? redirPc : pc_q;
    issue      = rst_n && !halt && (redirect_valid || (occAfter < CW'(DEPTH)));
    pc_d       = issue ? fetchPc + 32'd4 : fetchPc;
    tag_d      = issue ? fetchPc : tag_q;
    inflight_d = issue;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = occAfter;
    if (redirect_valid) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      if (push) wrPtr_d = wrPtr_q + PW'(1);
    end
  end

  assign imem_en     = issue;
  assign imem_addr   = fetchPc[IMEM_AW+1:2];
  assign if_id_valid = idValid;
  assign if_id_ir    = irMem_q[rdPtr_q];
  assign if_id_npc   = npcMem_q[rdPtr_q];
  assign fq_count    = count_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        irMem_q[i]  <= '0;
        npcMem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      if (push) begin
        irMem_q[wrPtr_q]  <= imem_rdata;
        npcMem_q[wrPtr_q] <= tag_q + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: a scoreboard predicts every fetch address and every delivered
// {ir, npc} pair, alongside directed checks for reset, back-pressure, redirect and halt.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } entry_t;

  logic        clk1;
  logic        rst_n;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [2:0]  fq_count;

  int          compared   = 0;
  int          mismatched = 0;
  int          fetchCount = 0;
  entry_t      sbq[$];
  logic        pend       = 1'b0;
  logic [31:0] pendPc     = '0;
  logic [31:0] expFetchPc = '0;

  if_prefetch_queue #(.DEPTH(DEPTH), .IMEM_AW(10), .RESET_PC(32'h0)) dut (
    .clk1(clk1), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir),
    .if_id_npc(if_id_npc), .id_ready(id_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .fq_count(fq_count)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  function automatic logic [31:0] memWord(input logic [9:0] a);
    return 32'h1000_0000 + {22'd0, a};
  endfunction

  // Instruction memory: one-cycle read latency
  always @(posedge clk1) begin
    if (imem_en) imem_rdata <= memWord(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic hlt, input logic rv, input logic [31:0] rpc);
    @(posedge clk1);
    #1;
    id_ready       = rdy;
    halt           = hlt;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic releaseReset(input logic rdy);
    @(posedge clk1);
    #1;
    rst_n          = 1'b1;
    id_ready       = rdy;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic pulseReset();
    @(posedge clk1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstPulseValid", 32'(if_id_valid), 32'd0);
    checkOutput("rstPulseCount", 32'(fq_count), 32'd0);
    checkOutput("rstPulseEn", 32'(imem_en), 32'd0);
    repeat (2) @(posedge clk1);
  endtask

  // Scoreboard: pops compared before this cycle's response is pushed, mirroring queue timing
  always @(negedge clk1) begin
    if (!rst_n) begin
      sbq.delete();
      pend       = 1'b0;
      expFetchPc = 32'h0;
      fetchCount = 0;
    end else begin
      checkOutput("count", 32'(fq_count), 32'(sbq.size()));
      checkOutput("valid", 32'(if_id_valid), 32'((sbq.size() != 0) && !redirect_valid));
      if (halt) checkOutput("haltNoFetch", 32'(imem_en), 32'd0);
      if (if_id_valid && id_ready) begin
        checkOutput("popNonEmpty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          entry_t e;
          e = sbq.pop_front();
          checkOutput("ir", if_id_ir, e.ir);
          checkOutput("npc", if_id_npc, e.npc);
        end
      end
      if (redirect_valid) begin
        sbq.delete();
        expFetchPc = redirect_pc & 32'hFFFF_FFFC;
      end else if (pend) begin
        sbq.push_back('{ir: memWord(pendPc[11:2]), npc: pendPc + 32'd4});
        checkOutput("noOverflow", 32'(sbq.size() <= DEPTH), 32'd1);
      end
      pend = 1'b0;
      if (imem_en) begin
        checkOutput("fetchAddr", 32'(imem_addr), 32'(expFetchPc[11:2]));
        pend       = 1'b1;
        pendPc     = expFetchPc;
        expFetchPc = expFetchPc + 32'd4;
        fetchCount++;
      end
    end
  end

  initial begin
    rst_n          = 1'b1;
    id_ready       = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rstValid", 32'(if_id_valid), 32'd0);
    checkOutput("rstEn", 32'(imem_en), 32'd0);
    checkOutput("rstCount", 32'(fq_count), 32'd0);
    checkOutput("rstIr", if_id_ir, 32'd0);
    checkOutput("rstNpc", if_id_npc, 32'd0);

    // Streaming with decode always ready
    releaseReset(1'b1);
    checkOutput("firstEn", 32'(imem_en), 32'd1);
    checkOutput("firstAddr", 32'(imem_addr), 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lat1Valid", 32'(if_id_valid), 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("lat2Valid", 32'(if_id_valid), 32'd1);
    checkOutput("lat2Ir", if_id_ir, 32'h1000_0000);
    checkOutput("lat2Npc", if_id_npc, 32'd4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("seqNpc", if_id_npc, 32'd8);
    repeat (6) applyStimulus(1, 0, 0, 0);

    // Mid-stream reset, then back-pressure from the first cycle
    pulseReset();
    releaseReset(1'b0);
    checkOutput("refetchEn", 32'(imem_en), 32'd1);
    checkOutput("refetchAddr", 32'(imem_addr), 32'd0);
    repeat (9) applyStimulus(0, 0, 0, 0);
    checkOutput("bpFetches", 32'(fetchCount), 32'd4);
    checkOutput("bpCount", 32'(fq_count), 32'd4);
    checkOutput("bpEn", 32'(imem_en), 32'd0);
    checkOutput("bpHeadIr", if_id_ir, 32'h1000_0000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("bpReleaseIr", if_id_ir, 32'h1000_0000);
    checkOutput("bpResumeEn", 32'(imem_en), 32'd1);
    checkOutput("bpResumeAddr", 32'(imem_addr), 32'd4);
    repeat (8) applyStimulus(1, 0, 0, 0);

    // Redirect with three queued entries and one read in flight
    pulseReset();
    releaseReset(1'b0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0040);
    checkOutput("redirOldCount", 32'(fq_count), 32'd3);
    checkOutput("redirValid", 32'(if_id_valid), 32'd0);
    checkOutput("redirEn", 32'(imem_en), 32'd1);
    checkOutput("redirAddr", 32'(imem_addr), 32'd16);
    applyStimulus(0, 0, 0, 0);
    checkOutput("redirFlushCount", 32'(fq_count), 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("redirNoStale", 32'(fq_count), 32'd1);
    checkOutput("redirIr", if_id_ir, 32'h1000_0010);
    checkOutput("redirNpc", if_id_npc, 32'h44);
    repeat (4) applyStimulus(1, 0, 0, 0);

    // Misaligned redirect target is treated as word aligned
    applyStimulus(1, 0, 1, 32'h0000_0043);
    checkOutput("misAddr", 32'(imem_addr), 32'd16);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("misIr", if_id_ir, 32'h1000_0010);
    checkOutput("misNpc", if_id_npc, 32'h44);
    repeat (4) applyStimulus(1, 0, 0, 0);

    // Halt mid-stream: outstanding read lands, queue drains, then fetch resumes in sequence
    applyStimulus(1, 1, 0, 0);
    checkOutput("haltEn", 32'(imem_en), 32'd0);
    repeat (4) applyStimulus(1, 1, 0, 0);
    checkOutput("haltDrained", 32'(fq_count), 32'd0);
    checkOutput("haltValid", 32'(if_id_valid), 32'd0);
    repeat (6) applyStimulus(1, 0, 0, 0);

    // Fill the queue, then sustain simultaneous push and pop
    repeat (8) applyStimulus(0, 0, 0, 0);
    checkOutput("fullCount", 32'(fq_count), 32'd4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("fullPopEn", 32'(imem_en), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("pushPopCount", 32'(fq_count), 32'd3);
    end
    repeat (3) applyStimulus(1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
